// File: rtl/bundle_fifo.sv
// bundle_fifo: first-word-fall-through FIFO of {ctrl, data} bundles with synchronous flush.
// Latency: a bundle pushed at edge N is visible on t__* right after edge N; head output is zero when empty.
// Backpressure: s__ready = !full, independent of t__ready (no bypass when full); optional level port under BUNDLE_FIFO_LEVEL_EN.

// Generic FWFT storage: wrap-bit pointers, unreset storage array, zeroed read data when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_fire;
    logic             rd_fire;

    // The extra pointer MSB distinguishes a full ring from an empty one.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign wr_rdy  = !full;
    assign rd_vld  = !empty;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_vld && rd_rdy;
    assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update: flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// Top: packs ctrl/data into one bundle word around the generic fifo.
module bundle_fifo #(
    parameter int BITS  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            s__valid,
    output logic            s__ready,
    input  logic [7:0]      s__ctrl,
    input  logic [BITS-1:0] s__data,
    output logic            t__valid,
    input  logic            t__ready,
    output logic [7:0]      t__ctrl,
    output logic [BITS-1:0] t__data,
    output logic            full,
    output logic            empty
`ifdef BUNDLE_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    typedef struct packed {
        logic [7:0]      ctrl;
        logic [BITS-1:0] data;
    } bundle_t;

    bundle_t s_bundle_dat;
    bundle_t t_bundle_dat;

    assign s_bundle_dat.ctrl = s__ctrl;
    assign s_bundle_dat.data = s__data;
    assign t__ctrl           = t_bundle_dat.ctrl;
    assign t__data           = t_bundle_dat.data;

    fifo #(
        .WIDTH ($bits(bundle_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_vld (s__valid),
        .wr_rdy (s__ready),
        .wr_dat (s_bundle_dat),
        .rd_vld (t__valid),
        .rd_rdy (t__ready),
        .rd_dat (t_bundle_dat),
        .full   (full),
        .empty  (empty)
    );

`ifdef BUNDLE_FIFO_LEVEL_EN
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic push_vld;
    logic pop_vld;

    assign push_vld = s__valid && s__ready;
    assign pop_vld  = t__valid && t__ready;

    // Occupancy counter tracks the pointers edge for edge, cleared with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else if (push_vld && !pop_vld) begin
            level <= level + LVL_ONE;
        end else if (pop_vld && !push_vld) begin
            level <= level - LVL_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_bundle_fifo.sv
// Bench for bundle_fifo: directed scenarios plus random traffic against a queue model.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
// Build with BUNDLE_FIFO_LEVEL_EN defined to also compare the level port.
module tb_bundle_fifo;

    localparam int BITS  = 32;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            s__valid;
    logic            s__ready;
    logic [7:0]      s__ctrl;
    logic [BITS-1:0] s__data;
    logic            t__valid;
    logic            t__ready;
    logic [7:0]      t__ctrl;
    logic [BITS-1:0] t__data;
    logic            full;
    logic            empty;
`ifdef BUNDLE_FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    bundle_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .s__valid (s__valid),
        .s__ready (s__ready),
        .s__ctrl  (s__ctrl),
        .s__data  (s__data),
        .t__valid (t__valid),
        .t__ready (t__ready),
        .t__ctrl  (t__ctrl),
        .t__data  (t__data),
        .full     (full),
        .empty    (empty)
`ifdef BUNDLE_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    typedef struct packed {
        logic [7:0]      c;
        logic [BITS-1:0] d;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the queue.
    task automatic chk_outputs(input string tag);
        logic       ev;
        logic [7:0] ec;
        logic [BITS-1:0] ed;
        ev = (q.size() != 0);
        ec = ev ? q[0].c : 8'h00;
        ed = ev ? q[0].d : '0;
        chk({tag, ".t_valid"}, 64'(t__valid), 64'(ev));
        chk({tag, ".t_ctrl"},  64'(t__ctrl),  64'(ec));
        chk({tag, ".t_data"},  64'(t__data),  64'(ed));
        chk({tag, ".empty"},   64'(empty),    64'(q.size() == 0));
        chk({tag, ".full"},    64'(full),     64'(q.size() == DEPTH));
        chk({tag, ".s_ready"}, 64'(s__ready), 64'(q.size() != DEPTH));
`ifdef BUNDLE_FIFO_LEVEL_EN
        chk({tag, ".level"},   64'(level),    64'(q.size()));
`endif
    endtask

    // One clock: drive, check at falling edge, then apply model rules at the rising edge.
    task automatic cycle(input string tag, input logic v, input logic [7:0] c,
                         input logic [BITS-1:0] d, input logic r, input logic f);
        bit do_push;
        bit do_pop;
        s__valid = v;
        s__ctrl  = c;
        s__data  = d;
        t__ready = r;
        flush    = f;
        @(negedge clk);
        chk_outputs(tag);
        do_push = v && (q.size() < DEPTH);
        do_pop  = r && (q.size() > 0);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{c: c, d: d});
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 8'h00, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) cycle(tag, 1'b0, 8'h00, '0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; s__valid = 1'b0; s__ctrl = '0; s__data = '0; t__ready = 1'b0;

        // Asynchronous reset: outputs settle before any clock edge.
        #3 rst_n = 1'b0;
        #1 chk_outputs("rst_async");
        @(posedge clk); #1;
        @(negedge clk);
        chk_outputs("rst_idle");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First edge with rst_n high accepts a push; FWFT shows it next cycle.
        cycle("push1", 1'b1, 8'h11, 32'hA0000001, 1'b0, 1'b0);
        idle("head1");
        cycle("flush1", 1'b0, 8'h00, '0, 1'b0, 1'b1);

        // Fill to full, refused fifth push, full with simultaneous pop, then drain in order.
        for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, 8'(i), 32'h1000 + i, 1'b0, 1'b0);
        cycle("full_push", 1'b1, 8'h05, 32'h1005, 1'b0, 1'b0);
        cycle("full_pushpop", 1'b1, 8'h06, 32'h1006, 1'b1, 1'b0);
        cycle("after_pushpop", 1'b1, 8'h07, 32'h1007, 1'b0, 1'b0);
        drain("drain");

        // Two entries held, push and pop together across pointer wrap.
        cycle("pre2a", 1'b1, 8'h20, 32'h2000, 1'b0, 1'b0);
        cycle("pre2b", 1'b1, 8'h21, 32'h2001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle("steady", 1'b1, 8'(8'h30 + i), 32'h3000 + i, 1'b1, 1'b0);
        drain("drain2");

        // Flush with a simultaneous push: the pushed bundle must never emerge.
        for (int i = 0; i < 3; i++) cycle("pre3", 1'b1, 8'(8'h40 + i), 32'h4000 + i, 1'b0, 1'b0);
        cycle("flush_push", 1'b1, 8'h55, 32'h5555, 1'b1, 1'b1);
        idle("post_flush");
        drain("drain3");

        // Reset dropped between edges with three entries held.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 8'(8'h60 + i), 32'h6000 + i, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk_outputs("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("new_a", 1'b1, 8'h71, 32'h7001, 1'b0, 1'b0);
        cycle("new_b", 1'b1, 8'h72, 32'h7002, 1'b0, 1'b0);
        drain("drain4");

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 99) < 60), 8'($urandom), 32'($urandom),
                  1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3));
        end
        drain("drain_rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bundle_fifo.md
BUNDLE_FIFO -- requirements
Module: bundle_fifo

Interface
REQ-001 Parameter BITS, default 32: width of the data field of the bundle.
REQ-002 Parameter DEPTH, default 4: number of bundle entries; power of two, at least 2.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port flush, input, 1: synchronous discard of all stored entries.
REQ-006 Port s__valid, input, 1: upstream bundle valid.
REQ-007 Port s__ready, output, 1: the block accepts a bundle this cycle.
REQ-008 Port s__ctrl, input, 8: upstream control byte.
REQ-009 Port s__data, input, BITS: upstream data word.
REQ-010 Port t__valid, output, 1: head bundle valid toward the downstream consumer.
REQ-011 Port t__ready, input, 1: downstream accepts the head bundle.
REQ-012 Port t__ctrl, output, 8: head control byte.
REQ-013 Port t__data, output, BITS: head data word.
REQ-014 Port full, output, 1: DEPTH entries are stored.
REQ-015 Port empty, output, 1: zero entries are stored.

Function
REQ-016 Push occurs when s__valid=1 and s__ready=1; pop occurs when t__valid=1 and t__ready=1.
REQ-017 s__ready SHALL equal !full, with no dependence on t__ready and no same-cycle bypass when full.
REQ-018 t__valid SHALL equal !empty.
REQ-019 t__ctrl and t__data SHALL present the oldest stored entry when t__valid=1, and SHALL be 0 when t__valid=0.
REQ-020 Latency: a bundle pushed at edge N SHALL appear on t__* immediately after edge N, in the following cycle. The block is first-word-fall-through.
REQ-021 Ordering: bundles SHALL leave in exactly push order, with ctrl and data of each bundle kept together.
REQ-022 Read and write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
- full = MSBs differ and low bits are equal.
- empty = pointers are equal.
REQ-023 Simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 When full, s__valid SHALL be ignored even if a pop occurs in the same cycle; the slot becomes writable in the next cycle.
REQ-025 When empty, no pop SHALL occur regardless of t__ready.
REQ-026 flush=1 at edge N SHALL zero both pointers, so empty=1 after edge N.
- Any push or pop presented in the same cycle SHALL be discarded.
REQ-027 t__valid SHALL be stable (not deasserted) until a pop occurs or flush is applied.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, zero both pointers.
- Resulting outputs: empty=1, full=0, s__ready=1, t__valid=0, t__ctrl=0, t__data=0.
REQ-029 Assertion of rst_n mid-operation SHALL discard all stored entries; storage contents need no reset.
REQ-030 Reset deassertion SHALL take effect synchronously; the first push is accepted at the first rising edge with rst_n=1.

Configuration
REQ-031 Macro BUNDLE_FIFO_LEVEL_EN defined: the block SHALL add output port level, width log2(DEPTH)+1.
- level equals the number of stored entries, 0..DEPTH.
- level is registered alongside the pointers, is 0 after reset and after flush, and is updated on the same edge as the pointers.
REQ-032 Macro BUNDLE_FIFO_LEVEL_EN undefined: port level and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset then idle -> empty=1, full=0, s__ready=1, t__valid=0, t__ctrl=0x00, t__data=0x0; level=0 when enabled.
REQ-034 Push ctrl=0x11/data=0xA0000001 with t__ready=0 -> next cycle t__valid=1, t__ctrl=0x11, t__data=0xA0000001, empty=0.
REQ-035 Push 4 bundles (ctrl 0x01..0x04) with t__ready=0 -> full=1, s__ready=0.
- A fifth push with s__valid=1 is not accepted.
- Then t__ready=1 drains 0x01,0x02,0x03,0x04 in order, one per cycle.
REQ-036 With 2 entries held, push and pop each cycle for 10 cycles -> count stays 2 and output order matches input order across pointer wrap.
REQ-037 With 3 entries, flush=1 together with s__valid=1 (ctrl 0x55) -> next cycle empty=1, t__valid=0, and 0x55 is never output.
REQ-038 With 3 entries, drop rst_n between clock edges -> t__valid=0 and s__ready=1 before the next edge; post-reset output sequence contains only new pushes.
